burst_col_addr_gen: RTL and testbench



---
 rtl/burst_col_addr_gen.sv | 109 ++++++++++
 tb/tb_burst_col_addr_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_col_addr_gen.sv
// rtl/burst_col_addr_gen.sv - burst column address generator driven by an external carry-mask stage
// Optional feature: define BURST_STOP_EN to let stop_i terminate a burst early.
module burst_col_addr_gen (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [7:0] start_col_i,
   input  logic [2:0] burst_length_i,
   input  logic       addr_mode_i,
   input  logic       stop_i,
   input  logic [7:0] carry_mask_i,
   output logic [2:0] cfg_burst_length_o,
   output logic       cfg_addr_mode_o,
   output logic [7:0] col_addr_o,
   output logic       col_valid_o,
   output logic       busy_o,
   output logic       burst_done_o
);

   typedef enum logic {IDLE, BURST} state_e;

   state_e     state_q;
   logic [7:0] col_addr_q;
   logic       col_valid_q;
   logic       busy_q;
   logic       done_q;
   logic [2:0] cfg_bl_q;
   logic       cfg_mode_q;
   logic [8:0] beat_cnt_q;

   logic [7:0] carry;
   logic [7:0] col_addr_d;
   logic [8:0] beat_total;
   logic [8:0] beat_cnt_d;
   logic       stop_hit;

`ifdef BURST_STOP_EN
   assign stop_hit = stop_i;
`else
   logic unused_stop;
   assign unused_stop = stop_i;
   assign stop_hit    = 1'b0;
`endif

   // Ripple increment gated per bit by the externally decoded mask; the wrap
   // boundary lives entirely in carry_mask_i, this block never decodes it.
   always_comb begin
      carry    = '0;
      carry[0] = carry_mask_i[0];
      for (int i = 1; i < 8; i++) begin
         carry[i] = col_addr_q[i-1] & carry[i-1] & carry_mask_i[i];
      end
      col_addr_d = col_addr_q ^ carry;
   end

   assign beat_total = (cfg_bl_q == 3'd7) ? 9'd256 : (9'd1 << cfg_bl_q);
   assign beat_cnt_d = beat_cnt_q + 9'd1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         col_addr_q  <= 8'h00;
         col_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_bl_q    <= 3'b000;
         cfg_mode_q  <= 1'b0;
         beat_cnt_q  <= 9'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q     <= BURST;
                  col_addr_q  <= start_col_i;
                  col_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= (burst_length_i == 3'd0);
                  cfg_bl_q    <= burst_length_i;
                  cfg_mode_q  <= addr_mode_i;
                  beat_cnt_q  <= 9'd1;
               end
            end
            BURST: begin
               // start_i is deliberately not looked at here, even on the final beat.
               if (done_q || stop_hit) begin
                  state_q     <= IDLE;
                  col_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b0;
                  beat_cnt_q  <= 9'd0;
               end else begin
                  col_addr_q  <= col_addr_d;
                  beat_cnt_q  <= beat_cnt_d;
                  done_q      <= (beat_cnt_d == beat_total);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_burst_length_o = cfg_bl_q;
   assign cfg_addr_mode_o    = cfg_mode_q;
   assign col_addr_o         = col_addr_q;
   assign col_valid_o        = col_valid_q;
   assign busy_o             = busy_q;
   assign burst_done_o       = done_q;

endmodule

// File: tb/tb_burst_col_addr_gen.sv
// tb/tb_burst_col_addr_gen.sv - randomized and directed bench for burst_col_addr_gen
module tb_burst_col_addr_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] start_col;
   logic [2:0] bl;
   logic       mode;
   logic       stop;
   logic [7:0] carry_mask;
   logic [2:0] cfg_bl;
   logic       cfg_mode;
   logic [7:0] col_addr;
   logic       col_valid;
   logic       busy;
   logic       burst_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   burst_col_addr_gen dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .start_i            (start),
      .start_col_i        (start_col),
      .burst_length_i     (bl),
      .addr_mode_i        (mode),
      .stop_i             (stop),
      .carry_mask_i       (carry_mask),
      .cfg_burst_length_o (cfg_bl),
      .cfg_addr_mode_o    (cfg_mode),
      .col_addr_o         (col_addr),
      .col_valid_o        (col_valid),
      .busy_o             (busy),
      .burst_done_o       (burst_done)
   );

   // Stand-in for the downstream carry-mask stage: carries enabled below the burst boundary.
   logic [8:0] low_mask;
   assign low_mask   = (9'd1 << cfg_bl) - 9'd1;
   assign carry_mask = (cfg_mode || cfg_bl == 3'd7) ? 8'hFF : (low_mask[7:0] | 8'h01);

   function automatic logic [7:0] exp_addr(input logic [7:0] col, input logic [2:0] code,
                                           input logic m, input int i);
      int s, len;
      s = int'(col) + i;
      if (m || code == 3'd7) return 8'(s % 256);
      len = 1 << code;
      return 8'((int'(col) / len) * len + (s % len));
   endfunction

   task automatic run_burst(input logic [7:0] col, input logic [2:0] code, input logic m,
                            input logic hold_start, input logic hold_stop);
      int n;
      logic [11:0] obs, expv;
      logic [3:0]  cobs, cexp;
      n = (code == 3'd7) ? 256 : (1 << code);
      @(negedge clk);
      start = 1'b1; start_col = col; bl = code; mode = m;
      @(negedge clk);
      if (hold_start) begin
         start_col = ~col; bl = ~code; mode = ~m;
      end else start = 1'b0;
      stop = hold_stop;
      for (int i = 0; i < n; i++) begin
         obs  = {col_valid, busy, burst_done, 1'b0, col_addr};
         expv = {1'b1, 1'b1, (i == n - 1), 1'b0, exp_addr(col, code, m, i)};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL beat col=%h code=%0d mode=%0b i=%0d got=%h want=%h", col, code, m, i, obs, expv);
         end
         cobs = {cfg_bl, cfg_mode};
         cexp = {code, m};
         total++;
         if (cobs !== cexp) begin
            bad++;
            $display("FAIL cfg i=%0d got=%h want=%h", i, cobs, cexp);
         end
         if (i < n - 1) @(negedge clk);
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 2; k++) begin
         obs  = {col_valid, busy, burst_done, 1'b0, col_addr};
         expv = {4'b0000, exp_addr(col, code, m, n - 1)};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL idle_after col=%h code=%0d k=%0d got=%h want=%h", col, code, k, obs, expv);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [14:0] obs;
      start = 1'b0; start_col = 8'h00; bl = 3'd0; mode = 1'b0; stop = 1'b0; rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      obs = {col_valid, busy, burst_done, col_addr, cfg_bl, cfg_mode};
      total++;
      if (obs !== 15'd0) begin
         bad++;
         $display("FAIL reset_value got=%h want=0", obs);
      end
      start = 1'b1; start_col = 8'h55; bl = 3'd3;
      repeat (2) @(negedge clk);
      obs = {col_valid, busy, burst_done, col_addr, cfg_bl, cfg_mode};
      total++;
      if (obs !== 15'd0) begin
         bad++;
         $display("FAIL reset_hold got=%h want=0", obs);
      end
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      run_burst(8'h06, 3'd2, 1'b0, 1'b0, 1'b0);
      run_burst(8'h06, 3'd2, 1'b1, 1'b0, 1'b0);
      run_burst(8'hFD, 3'd3, 1'b0, 1'b1, 1'b0);
      run_burst(8'hFE, 3'd7, 1'b0, 1'b0, 1'b0);
      run_burst(8'h3C, 3'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random;
      logic [7:0] col;
      logic [2:0] code;
      logic       m, hs, hp;
      for (int t = 0; t < 25; t++) begin
         col  = 8'($urandom);
         code = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         m    = 1'($urandom);
         hs   = 1'($urandom);
`ifdef BURST_STOP_EN
         hp   = 1'b0;
`else
         hp   = 1'($urandom);
`endif
         run_burst(col, code, m, hs, hp);
      end
   endtask

   task automatic test_reset_mid_burst;
      logic [14:0] obs;
      logic [11:0] bobs, bexp;
      @(negedge clk);
      start = 1'b1; start_col = 8'hA5; bl = 3'd3; mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      bobs = {col_valid, busy, burst_done, 1'b0, col_addr};
      bexp = {3'b110, 1'b0, exp_addr(8'hA5, 3'd3, 1'b0, 1)};
      total++;
      if (bobs !== bexp) begin
         bad++;
         $display("FAIL midrst_beat2 got=%h want=%h", bobs, bexp);
      end
      rst_n = 1'b0;
      #1;
      obs = {col_valid, busy, burst_done, col_addr, cfg_bl, cfg_mode};
      total++;
      if (obs !== 15'd0) begin
         bad++;
         $display("FAIL midrst_immediate got=%h want=0", obs);
      end
      repeat (2) @(negedge clk);
      obs = {col_valid, busy, burst_done, col_addr, cfg_bl, cfg_mode};
      total++;
      if (obs !== 15'd0) begin
         bad++;
         $display("FAIL midrst_no_done got=%h want=0", obs);
      end
      rst_n = 1'b1; start = 1'b1; start_col = 8'h3C; bl = 3'd0; mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bobs = {col_valid, busy, burst_done, 1'b0, col_addr};
      bexp = {3'b111, 1'b0, 8'h3C};
      total++;
      if (bobs !== bexp) begin
         bad++;
         $display("FAIL start_after_release got=%h want=%h", bobs, bexp);
      end
      @(negedge clk);
      bobs = {col_valid, busy, burst_done, 1'b0, col_addr};
      bexp = {4'b0000, 8'h3C};
      total++;
      if (bobs !== bexp) begin
         bad++;
         $display("FAIL idle_after_release got=%h want=%h", bobs, bexp);
      end
   endtask

`ifdef BURST_STOP_EN
   task automatic test_stop;
      logic [11:0] obs, expv;
      @(negedge clk);
      start = 1'b1; start_col = 8'hFE; bl = 3'd7; mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         obs  = {col_valid, busy, burst_done, 1'b0, col_addr};
         expv = {3'b110, 1'b0, exp_addr(8'hFE, 3'd7, 1'b0, i)};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL stop_pre i=%0d got=%h want=%h", i, obs, expv);
         end
         if (i < 2) @(negedge clk);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      obs  = {col_valid, busy, burst_done, 1'b0, col_addr};
      expv = {4'b0000, 8'h00};
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL stop_end got=%h want=%h", obs, expv);
      end
      stop = 1'b1; start = 1'b1; start_col = 8'h10; bl = 3'd1; mode = 1'b1;
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
      obs  = {col_valid, busy, burst_done, 1'b0, col_addr};
      expv = {3'b110, 1'b0, 8'h10};
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL stop_idle_ignored got=%h want=%h", obs, expv);
      end
      @(negedge clk);
      obs  = {col_valid, busy, burst_done, 1'b0, col_addr};
      expv = {3'b111, 1'b0, 8'h11};
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL stop_idle_second got=%h want=%h", obs, expv);
      end
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid_burst();
`ifdef BURST_STOP_EN
      test_stop();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1);
   end

endmodule
